// File: rtl/dog_window_gen_if.sv
// Stream interface for the scale-space window generator.
//   master: producer side (drives the three layer samples, sees the windows)
//   slave : generator side (takes the samples, drives windows/centre/flags)
// Signals:
//   din_valid, sof           - sample qualifier and start-of-frame marker
//   top_din/mid_din/low_din  - signed DoG samples for upper/middle/lower scale
//   top/mid/low_window       - 3x3 windows, element (i,j) at ((i-1)*3+(j-1))*DATA_WIDTH
//   center_x, center_y       - window centre position
//   dout_valid, frame_done   - window valid flag and last-window-of-frame pulse
interface dog_window_gen_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic                    din_valid;
  logic                    sof;
  logic [DATA_WIDTH-1:0]   top_din;
  logic [DATA_WIDTH-1:0]   mid_din;
  logic [DATA_WIDTH-1:0]   low_din;
  logic [9*DATA_WIDTH-1:0] top_window;
  logic [9*DATA_WIDTH-1:0] mid_window;
  logic [9*DATA_WIDTH-1:0] low_window;
  logic [CW-1:0]           center_x;
  logic [RW-1:0]           center_y;
  logic                    dout_valid;
  logic                    frame_done;

  modport master (
    output din_valid, sof, top_din, mid_din, low_din,
    input  top_window, mid_window, low_window, center_x, center_y, dout_valid, frame_done
  );

  modport slave (
    input  din_valid, sof, top_din, mid_din, low_din,
    output top_window, mid_window, low_window, center_x, center_y, dout_valid, frame_done
  );
endinterface

// File: rtl/dog_window_gen.sv
// Scale-space 3x3x3 window generator.
// Buffers two lines per DoG layer and forms the 3x3 neighbourhood of each
// interior pixel for the upper, middle and lower scale, one pixel per cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (priority over any sample that cycle)
//   bus  - dog_window_gen_if.slave: sample stream in, windows/centre/flags out
module dog_window_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input logic             clk,
  input logic             rst,
  dog_window_gen_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col, pcol;
  logic [RW-1:0] row, prow;
  logic          last_col, last_row, interior;

  logic [DATA_WIDTH-1:0] din    [3];
  logic [DATA_WIDTH-1:0] lb0    [3][IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1    [3][IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb0_rd [3];
  logic [DATA_WIDTH-1:0] lb1_rd [3];
  logic [8:0][DATA_WIDTH-1:0] win [3];

  logic          valid_q, done_q;
  logic [CW-1:0] cx_q;
  logic [RW-1:0] cy_q;

  assign din[0] = bus.top_din;
  assign din[1] = bus.mid_din;
  assign din[2] = bus.low_din;

  // Position of the pixel being accepted this cycle; sof overrides the counters.
  always_comb begin
    pcol = col;
    prow = row;
    if (bus.din_valid && bus.sof) begin
      pcol = '0;
      prow = '0;
    end
  end

  assign last_col = (pcol == COL_LAST);
  assign last_row = (prow == ROW_LAST);
  assign interior = (pcol >= CW'(2)) && (prow >= RW'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (bus.din_valid) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : prow + RW'(1);
      end else begin
        col <= pcol + CW'(1);
        row <= prow;
      end
    end
  end

  always_comb begin
    for (int l = 0; l < 3; l++) begin
      lb0_rd[l] = lb0[l][pcol];
      lb1_rd[l] = lb1[l][pcol];
    end
  end

  // Line buffers are deliberately not cleared; stale lines are masked by the
  // interior test until two fresh lines have been written.
  always_ff @(posedge clk) begin
    if (!rst && bus.din_valid) begin
      for (int l = 0; l < 3; l++) begin
        lb1[l][pcol] <= lb0[l][pcol];
        lb0[l][pcol] <= din[l];
      end
    end
  end

  // Window: index (i-1)*3+(j-1); columns shift toward j=1, newest column
  // loads {row r-2, row r-1, row r} into rows 1/2/3.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < 3; l++) win[l] <= '0;
    end else if (bus.din_valid) begin
      for (int l = 0; l < 3; l++) begin
        for (int i = 0; i < 3; i++) begin
          win[l][i*3+0] <= win[l][i*3+1];
          win[l][i*3+1] <= win[l][i*3+2];
        end
        win[l][2] <= lb1_rd[l];
        win[l][5] <= lb0_rd[l];
        win[l][8] <= din[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      valid_q <= bus.din_valid && interior;
      done_q  <= bus.din_valid && last_col && last_row;
      if (bus.din_valid && interior) begin
        cx_q <= pcol - CW'(1);
        cy_q <= prow - RW'(1);
      end
    end
  end

  assign bus.top_window = win[0];
  assign bus.mid_window = win[1];
  assign bus.low_window = win[2];
  assign bus.center_x   = cx_q;
  assign bus.center_y   = cy_q;
  assign bus.dout_valid = valid_q;
  assign bus.frame_done = done_q;
endmodule
